// File: rtl/spi_rx_deserializer.sv
// SPI receive deserializer: assembles DATA_WIDTH sampled bits into a word and
// hands completed words off through a valid/ready holding register.
module spi_rx_deserializer #(
    parameter int DATA_WIDTH = 8,
    localparam int CNT_W = $clog2(DATA_WIDTH)
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_sclk_enable,
    input  logic                  i_shift_enable,
    input  logic                  i_serial_in,
    input  logic                  i_MSB,
    input  logic                  i_ready,
    input  logic                  i_clear_errors,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_valid,
    output logic                  o_busy,
    output logic                  o_overrun,
    output logic                  o_abort
);

    logic [DATA_WIDTH-1:0] sreg_q, sreg_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  msb_q, msb_d;
    logic                  valid_q, valid_d;
    logic                  overrun_q, overrun_d;
    logic                  abort_q, abort_d;

    logic [DATA_WIDTH-1:0] shifted;
    logic                  order;
    logic                  last_bit;
    logic                  complete;
    logic                  overrun_set;
    logic                  abort_set;

    // The first bit of a word follows i_MSB live; later bits use the latched order.
    assign order    = (cnt_q == '0) ? i_MSB : msb_q;
    assign shifted  = order ? {sreg_q[DATA_WIDTH-2:0], i_serial_in}
                            : {i_serial_in, sreg_q[DATA_WIDTH-1:1]};
    assign last_bit = (cnt_q == CNT_W'(DATA_WIDTH - 1));

    always_comb begin
        sreg_d      = sreg_q;
        cnt_d       = cnt_q;
        msb_d       = msb_q;
        complete    = 1'b0;
        abort_set   = 1'b0;

        if (!i_shift_enable) begin
            if (cnt_q != '0) begin
                cnt_d     = '0;
                sreg_d    = '0;
                abort_set = 1'b1;
            end
        end else if (i_sclk_enable) begin
            sreg_d = shifted;
            if (cnt_q == '0) begin
                msb_d = i_MSB;
            end
            if (last_bit) begin
                cnt_d    = '0;
                complete = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_comb begin
        data_d      = data_q;
        valid_d     = valid_q;
        overrun_set = 1'b0;

        if (valid_q && i_ready) begin
            valid_d = 1'b0;
        end
        // A word completing into a full, unconsumed holding register is dropped.
        if (complete) begin
            if (!valid_q || i_ready) begin
                data_d  = shifted;
                valid_d = 1'b1;
            end else begin
                overrun_set = 1'b1;
            end
        end
    end

    always_comb begin
        overrun_d = overrun_q;
        abort_d   = abort_q;
        if (i_clear_errors) begin
            overrun_d = 1'b0;
            abort_d   = 1'b0;
        end
        if (overrun_set) begin
            overrun_d = 1'b1;
        end
        if (abort_set) begin
            abort_d = 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            sreg_q    <= '0;
            data_q    <= '0;
            cnt_q     <= '0;
            msb_q     <= 1'b1;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
            abort_q   <= 1'b0;
        end else begin
            sreg_q    <= sreg_d;
            data_q    <= data_d;
            cnt_q     <= cnt_d;
            msb_q     <= msb_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
            abort_q   <= abort_d;
        end
    end

    assign o_data    = data_q;
    assign o_valid   = valid_q;
    assign o_busy    = (cnt_q != '0);
    assign o_overrun = overrun_q;
    assign o_abort   = abort_q;

endmodule

// File: tb/tb_spi_rx_deserializer.sv
// Bench for spi_rx_deserializer: an 8-bit and a 16-bit instance share stimulus
// and are compared every cycle against a bit-list reference model.
module tb_spi_rx_deserializer;

    logic        i_clk = 1'b0;
    logic        i_reset;
    logic        sclk, se8, se16, sin, msb, rdy, clr;
    logic [7:0]  d8;
    logic        v8, b8, ov8, ab8;
    logic [15:0] d16;
    logic        v16, b16, ov16, ab16;

    always #5 i_clk = ~i_clk;

    spi_rx_deserializer #(.DATA_WIDTH(8)) u_dut8 (
        .i_clk(i_clk), .i_reset(i_reset), .i_sclk_enable(sclk),
        .i_shift_enable(se8), .i_serial_in(sin), .i_MSB(msb), .i_ready(rdy),
        .i_clear_errors(clr), .o_data(d8), .o_valid(v8), .o_busy(b8),
        .o_overrun(ov8), .o_abort(ab8)
    );

    spi_rx_deserializer #(.DATA_WIDTH(16)) u_dut16 (
        .i_clk(i_clk), .i_reset(i_reset), .i_sclk_enable(sclk),
        .i_shift_enable(se16), .i_serial_in(sin), .i_MSB(msb), .i_ready(rdy),
        .i_clear_errors(clr), .o_data(d16), .o_valid(v16), .o_busy(b16),
        .o_overrun(ov16), .o_abort(ab16)
    );

    // Reference model: the bits of the current frame are kept as a list and
    // the word is formed arithmetically when the list reaches the word length.
    int          wlen [2] = '{8, 16};
    int          nbits [2];
    bit          fb [2][32];
    bit          ord [2];
    logic [31:0] m_data [2];
    bit          m_valid [2];
    bit          m_ov [2];
    bit          m_ab [2];

    int vectors = 0;
    int miscompares = 0;
    bit rnd = 1'b0;

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            nbits[k]   = 0;
            ord[k]     = 1'b1;
            m_data[k]  = '0;
            m_valid[k] = 1'b0;
            m_ov[k]    = 1'b0;
            m_ab[k]    = 1'b0;
        end
    endtask

    task automatic model_step();
        for (int k = 0; k < 2; k++) begin
            logic        se;
            bit          compl, ov_set, ab_set;
            logic [31:0] word;
            se     = (k == 0) ? se8 : se16;
            compl  = 1'b0;
            ov_set = 1'b0;
            ab_set = 1'b0;
            word   = '0;
            if (!se) begin
                if (nbits[k] != 0) begin
                    nbits[k] = 0;
                    ab_set   = 1'b1;
                end
            end else if (sclk) begin
                if (nbits[k] == 0) ord[k] = msb;
                fb[k][nbits[k]] = sin;
                nbits[k]++;
                if (nbits[k] == wlen[k]) begin
                    for (int i = 0; i < wlen[k]; i++) begin
                        if (fb[k][i]) begin
                            if (ord[k]) word = word + (32'd1 << (wlen[k] - 1 - i));
                            else        word = word + (32'd1 << i);
                        end
                    end
                    compl    = 1'b1;
                    nbits[k] = 0;
                end
            end
            if (compl) begin
                if (!m_valid[k] || rdy) begin
                    m_data[k]  = word;
                    m_valid[k] = 1'b1;
                end else begin
                    ov_set = 1'b1;
                end
            end else if (m_valid[k] && rdy) begin
                m_valid[k] = 1'b0;
            end
            if (clr) begin
                m_ov[k] = 1'b0;
                m_ab[k] = 1'b0;
            end
            if (ov_set) m_ov[k] = 1'b1;
            if (ab_set) m_ab[k] = 1'b1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("data8",     {24'd0, d8},  m_data[0]);
        chk("valid8",    {31'd0, v8},  {31'd0, m_valid[0]});
        chk("busy8",     {31'd0, b8},  {31'd0, nbits[0] != 0});
        chk("overrun8",  {31'd0, ov8}, {31'd0, m_ov[0]});
        chk("abort8",    {31'd0, ab8}, {31'd0, m_ab[0]});
        chk("data16",    {16'd0, d16}, m_data[1]);
        chk("valid16",   {31'd0, v16}, {31'd0, m_valid[1]});
        chk("busy16",    {31'd0, b16}, {31'd0, nbits[1] != 0});
        chk("overrun16", {31'd0, ov16}, {31'd0, m_ov[1]});
        chk("abort16",   {31'd0, ab16}, {31'd0, m_ab[1]});
    endtask

    task automatic tick();
        model_step();
        @(posedge i_clk);
        #1;
        check_all();
    endtask

    task automatic send_bit(input int k, input bit b, input bit msbv, input bit gap);
        se8  = (k == 0);
        se16 = (k == 1);
        sclk = 1'b1;
        sin  = b;
        msb  = msbv;
        if (rnd) begin
            rdy = 1'($urandom_range(0, 1));
            clr = ($urandom_range(0, 15) == 0);
        end
        tick();
        sclk = 1'b0;
        clr  = 1'b0;
        sin  = 1'($urandom_range(0, 1));
        msb  = 1'($urandom_range(0, 1));
        if (gap && $urandom_range(0, 2) == 0) tick();
    endtask

    // rdy_last >= 0 forces i_ready to that value on the completing strobe.
    task automatic send_word(input int k, input logic [31:0] val, input bit msbf,
                             input bit scr, input int rdy_last);
        for (int i = 0; i < wlen[k]; i++) begin
            bit b, m;
            b = msbf ? val[wlen[k] - 1 - i] : val[i];
            m = (i == 0 || !scr) ? msbf : 1'($urandom_range(0, 1));
            if (i == wlen[k] - 1 && rdy_last >= 0) rdy = rdy_last[0];
            send_bit(k, b, m, i != wlen[k] - 1);
        end
    endtask

    initial begin
        i_reset = 1'b0;
        {sclk, se8, se16, sin, msb, rdy, clr} = '0;
        model_reset();
        #1;
        chk("reset_data8", {24'd0, d8}, 32'd0);
        chk("reset_valid8", {31'd0, v8}, 32'd0);
        chk("reset_busy8", {31'd0, b8}, 32'd0);
        check_all();
        repeat (2) @(negedge i_clk);
        i_reset = 1'b1;

        // MSB first 0xA5, consumer always ready
        rdy = 1'b1;
        send_word(0, 32'hA5, 1'b1, 1'b0, -1);
        chk("t1_valid", {31'd0, v8}, 32'd1);
        chk("t1_data", {24'd0, d8}, 32'hA5);
        chk("t1_busy", {31'd0, b8}, 32'd0);
        tick();
        chk("t1_valid_drop", {31'd0, v8}, 32'd0);

        // LSB first 1,0,1,0,0,1,0,1 with i_MSB scrambled after the first bit
        send_word(0, 32'hA5, 1'b0, 1'b1, -1);
        chk("t2_data", {24'd0, d8}, 32'hA5);
        tick();

        // 16-bit overrun: second word dropped while the first is unconsumed
        se8 = 1'b0;
        rdy = 1'b0;
        send_word(1, 32'h1234, 1'b1, 1'b0, -1);
        tick();
        send_word(1, 32'hBEEF, 1'b1, 1'b0, -1);
        tick();
        chk("t3_data", {16'd0, d16}, 32'h1234);
        chk("t3_valid", {31'd0, v16}, 32'd1);
        chk("t3_overrun", {31'd0, ov16}, 32'd1);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("t3_clear", {31'd0, ov16}, 32'd0);
        rdy = 1'b1;
        tick();
        se16 = 1'b0;

        // Consume and reload in the same cycle
        rdy = 1'b0;
        send_word(0, 32'h11, 1'b1, 1'b0, -1);
        chk("t4_first", {24'd0, d8}, 32'h11);
        send_word(0, 32'h22, 1'b1, 1'b0, 1);
        chk("t4_valid", {31'd0, v8}, 32'd1);
        chk("t4_data", {24'd0, d8}, 32'h22);
        chk("t4_overrun", {31'd0, ov8}, 32'd0);
        rdy = 1'b0;
        tick();

        // Abort after 5 of 8 bits, then a full 0x3C frame
        for (int i = 0; i < 5; i++) send_bit(0, 1'($urandom_range(0, 1)), 1'b1, 1'b1);
        se8 = 1'b0;
        tick();
        chk("t5_abort", {31'd0, ab8}, 32'd1);
        chk("t5_busy", {31'd0, b8}, 32'd0);
        chk("t5_valid", {31'd0, v8}, 32'd1);
        chk("t5_hold", {24'd0, d8}, 32'h22);
        rdy = 1'b1;
        tick();
        send_word(0, 32'h3C, 1'b1, 1'b0, -1);
        chk("t5_data", {24'd0, d8}, 32'h3C);
        clr = 1'b1;
        tick();
        clr = 1'b0;

        // Asynchronous reset mid-word with a word held
        rdy = 1'b0;
        send_word(0, 32'h5A, 1'b1, 1'b0, -1);
        for (int i = 0; i < 4; i++) send_bit(0, 1'b1, 1'b1, 1'b0);
        chk("t6_pre_valid", {31'd0, v8}, 32'd1);
        #2;
        i_reset = 1'b0;
        #1;
        model_reset();
        chk("t6_data", {24'd0, d8}, 32'd0);
        chk("t6_valid", {31'd0, v8}, 32'd0);
        chk("t6_busy", {31'd0, b8}, 32'd0);
        check_all();
        {sclk, se8, se16} = '0;
        repeat (2) @(negedge i_clk);
        i_reset = 1'b1;
        rdy = 1'b1;
        send_word(0, 32'hC3, 1'b1, 1'b0, -1);
        chk("t6_after", {24'd0, d8}, 32'hC3);
        tick();

        // Randomized frames: both widths, both orders, random ready/clear, aborts
        rnd = 1'b1;
        for (int n = 0; n < 60; n++) begin
            int          k, r;
            logic [31:0] val;
            bit          mf;
            k   = $urandom_range(0, 1);
            val = $urandom;
            mf  = 1'($urandom_range(0, 1));
            r   = $urandom_range(0, 5);
            if (r == 0) begin
                int nb;
                nb = $urandom_range(1, wlen[k] - 1);
                for (int i = 0; i < nb; i++) send_bit(k, 1'($urandom_range(0, 1)), mf, 1'b1);
                se8  = 1'b0;
                se16 = 1'b0;
                sclk = 1'($urandom_range(0, 1));
                tick();
                sclk = 1'b0;
            end else begin
                send_word(k, val, mf, r == 1, -1);
            end
            if ($urandom_range(0, 1) == 1) begin
                rdy = 1'($urandom_range(0, 1));
                tick();
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/spi_rx_deserializer.md
Name: spi_rx_deserializer

Overview:
Parametrised SPI receive deserializer, the successor to the fixed 8-bit RX shift register. It assembles DATA_WIDTH serial bits into a word and counts bits internally. Completed words are handed off through a holding register with a valid/ready handshake, so the SPI core no longer tracks bit positions. It flags overrun and aborted (partial) frames, and sits between the SPI slave/master front end (which supplies the sample strobe) and the RX FIFO or user logic.

Parameters:
DATA_WIDTH, 8, word length in bits; legal range 2..32.
CNT_W, $clog2(DATA_WIDTH), bit-counter width; derived, never overridden.

Ports:
i_clk  input  1  system clock; all logic on the rising edge.
i_reset  input  1  asynchronous, active-low reset.
i_sclk_enable  input  1  one-cycle sample strobe at the SCLK sampling edge.
i_shift_enable  input  1  frame active (CS asserted); low aborts or idles the block.
i_serial_in  input  1  serial data bit (MOSI/MISO), already synchronised.
i_MSB  input  1  bit order: 1 = MSB first, 0 = LSB first; latched at bit 0 of each word.
i_ready  input  1  consumer accepts o_data when o_valid is high.
i_clear_errors  input  1  clears o_overrun and o_abort.
o_data  output  DATA_WIDTH  last completed word, right-justified, bit order normalised.
o_valid  output  1  o_data holds an unconsumed word.
o_busy  output  1  partial word in progress (bit counter != 0).
o_overrun  output  1  sticky: a word completed while the holding register was full.
o_abort  output  1  sticky: i_shift_enable fell with a partial word pending.

Behaviour:
- Reset (asynchronous, active-low) clears every register. Outputs: o_data=0, o_valid=0, o_busy=0, o_overrun=0, o_abort=0. Internal state: shift register=0, bit counter=0, latched order=1 (MSB first).
- Sample event = i_shift_enable & i_sclk_enable.
- On a sample event with counter=0, the bit order for this word is taken from i_MSB and latched. Later changes of i_MSB do not affect the word in progress.
- Shift rule on a sample event:
  - MSB first: sreg <= {sreg[W-2:0], bit}.
  - LSB first: sreg <= {bit, sreg[W-1:1]}.
  - Bit 0 uses i_MSB directly; later bits use the latched order.
- The counter increments on each sample event and wraps from DATA_WIDTH-1 to 0. o_busy = (counter != 0).
- Word completion is the sample event with counter = DATA_WIDTH-1. The completed word is the next-state shift value, including the current bit.
- Holding register, at completion:
  - If o_valid=0, or o_valid=1 with i_ready=1 in the same cycle: o_data <= completed word and o_valid <= 1 on the next edge. Latency is one clock from the final sample strobe.
  - If o_valid=1 and i_ready=0: the new word is dropped, o_data is unchanged, and o_overrun <= 1.
- Handshake: o_valid falls on the edge after o_valid & i_ready, unless a completion reloads it in that same cycle. o_data is stable while o_valid=1 and i_ready=0.
- Abort: i_shift_enable=0 with counter!=0 clears the counter and shift register on the next edge and sets o_abort. The partial word is discarded. The holding register and o_valid are unaffected.
- i_shift_enable=0 with counter=0 is idle: no flag is set and state is held.
- i_sclk_enable with i_shift_enable=0 is ignored.
- i_clear_errors clears o_overrun and o_abort on the next edge. If a set condition occurs in the same cycle, set wins.
- Consecutive words back-to-back, with no idle strobe between them, are supported.

Test Plan:
- DATA_WIDTH=8, i_MSB=1, shift 0xA5 bit by bit with i_ready=1 -> o_valid high for 1 cycle, one clock after the 8th strobe, with o_data=0xA5; o_busy high from the 1st strobe until the 8th.
- DATA_WIDTH=8, i_MSB=0, send serial sequence 1,0,1,0,0,1,0,1 -> o_data=0xA5. Toggle i_MSB after bit 3 -> result still 0xA5.
- DATA_WIDTH=16, i_ready=0, send 0x1234 then 0xBEEF -> o_data stays 0x1234, o_valid=1, o_overrun=1. Pulse i_clear_errors -> o_overrun=0.
- o_valid=1 with 0x11; assert i_ready in the same cycle the next word 0x22 completes -> o_valid remains 1, o_data=0x22, o_overrun=0.
- Deassert i_shift_enable after 5 of 8 bits -> o_abort=1, o_busy=0, o_valid unchanged. A following full 0x3C frame -> o_data=0x3C.
- Assert i_reset low mid-word (counter=4, o_valid=1) -> all outputs 0 immediately, without waiting for a clock edge. After release, a fresh 8-bit word is received correctly.
